// File: rtl/gate_op_arbiter_pkg.sv
// Shared constants and types for the gate-op arbiter: opcodes, gate output
// bit positions and the sequencer state encoding.
package gate_op_pkg;

    localparam logic [2:0] OP_AND     = 3'd0;
    localparam logic [2:0] OP_OR      = 3'd1;
    localparam logic [2:0] OP_NAND    = 3'd2;
    localparam logic [2:0] OP_NOR     = 3'd3;
    localparam logic [2:0] OP_XOR     = 3'd4;
    localparam logic [2:0] OP_XNOR    = 3'd5;
    localparam logic [2:0] OP_NOT     = 3'd6;
    localparam logic [2:0] OP_ILLEGAL = 3'd7;

    // Positions inside the packed {g,f,e,d,c,b,a} gate output word
    localparam int GU_A_BIT = 0;
    localparam int GU_B_BIT = 1;
    localparam int GU_C_BIT = 2;
    localparam int GU_D_BIT = 3;
    localparam int GU_E_BIT = 4;
    localparam int GU_F_BIT = 5;
    localparam int GU_G_BIT = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/gate_op_arbiter_if.sv
// Requester/consumer side bus of the gate-op arbiter. The arbiter takes the
// slave view; the requester fabric (or bench) takes the master view.
interface gate_op_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   req_x;
    logic [NUM_REQ-1:0]   req_y;
    logic [3*NUM_REQ-1:0] req_op;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic                 rsp_data;
    logic                 rsp_err;

    modport master (
        output req_valid, req_x, req_y, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_x, req_y, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );

endinterface

// File: rtl/gate_op_arbiter_rr_picker.sv
// Combinational round-robin search: first valid requester at or above rr_ptr,
// wrapping modulo NUM_REQ. Produces one-hot grant, its index and any_valid.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               any_valid
);

    logic [ID_W-1:0] idx;

    // Scan from the farthest offset down so the nearest hit wins.
    always_comb begin
        grant_idx = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (req_valid[idx]) begin
                grant_idx = idx;
                any_valid = 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign grant[gi] = any_valid && (grant_idx == ID_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/logic_gates.sv
// The shared two-input logic unit: seven gate outputs from one operand pair.
module logic_gates
    import gate_op_pkg::*;
(
    input  logic       x,
    input  logic       y,
    output logic [6:0] gates
);

    assign gates[GU_A_BIT] = x & y;
    assign gates[GU_B_BIT] = x | y;
    assign gates[GU_C_BIT] = ~(x & y);
    assign gates[GU_D_BIT] = ~(x | y);
    assign gates[GU_E_BIT] = x ^ y;
    assign gates[GU_F_BIT] = ~(x ^ y);
    assign gates[GU_G_BIT] = ~x;

endmodule

// File: rtl/gate_op_arbiter.sv
// Round-robin arbiter that time-shares one logic_gates unit between NUM_REQ
// requesters and returns the selected gate result tagged with the owner ID.
module gate_op_arbiter
    import gate_op_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    gate_op_arbiter_if.slave  bus,
    output logic              gu_x,
    output logic              gu_y,
    input  logic [6:0]        gu_out,
    output logic              busy
);

    localparam int ID_W = $clog2(NUM_REQ);

    state_t              state_reg, state_next;
    logic [ID_W-1:0]     rr_ptr_reg;
    logic                x_reg, y_reg;
    logic [2:0]          op_reg;
    logic [ID_W-1:0]     id_reg;
    logic                rsp_valid_reg, rsp_data_reg, rsp_err_reg;
    logic [ID_W-1:0]     rsp_id_reg;

    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_idx;
    logic                any_valid;
    logic                accept;
    logic [2:0]          op_arr [NUM_REQ];
    logic [7:0]          gates_ext;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req_valid (bus.req_valid),
        .rr_ptr    (rr_ptr_reg),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_valid (any_valid)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_op_unpack
            assign op_arr[gi] = bus.req_op[3*gi +: 3];
        end
    endgenerate

    assign accept = (state_reg == IDLE) && any_valid;
    // Bit 7 pads the word so the illegal opcode selects a constant 0.
    assign gates_ext = {1'b0, gu_out};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (any_valid) state_next = EVAL;
            EVAL:    state_next = RESP;
            RESP:    if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = accept ? grant : '0;
        busy          = (state_reg != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg    <= '0;
            x_reg         <= 1'b0;
            y_reg         <= 1'b0;
            op_reg        <= 3'd0;
            id_reg        <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= '0;
            rsp_data_reg  <= 1'b0;
            rsp_err_reg   <= 1'b0;
        end else begin
            if (accept) begin
                x_reg      <= bus.req_x[grant_idx];
                y_reg      <= bus.req_y[grant_idx];
                op_reg     <= op_arr[grant_idx];
                id_reg     <= grant_idx;
                rr_ptr_reg <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
            end
            if (state_reg == EVAL) begin
                rsp_valid_reg <= 1'b1;
                rsp_id_reg    <= id_reg;
                rsp_data_reg  <= gates_ext[op_reg];
                rsp_err_reg   <= (op_reg == OP_ILLEGAL);
            end
            if (state_reg == RESP && bus.rsp_ready) begin
                rsp_valid_reg <= 1'b0;
            end
        end
    end

    assign gu_x          = x_reg;
    assign gu_y          = y_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_id    = rsp_id_reg;
    assign bus.rsp_data  = rsp_data_reg;
    assign bus.rsp_err   = rsp_err_reg;

endmodule

// File: doc/gate_op_arbiter.md
Name: gate_op_arbiter

Overview:
Round-robin arbiter and sequencer that shares one combinational logic_gates unit between NUM_REQ requesters. Each requester submits an operand pair (x, y) plus an opcode selecting one of the seven gate outputs. The block drives the shared unit, samples the selected output and returns a one-bit result tagged with the requester ID. It sits between the requester fabric and the single logic_gates instance.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..16.
ID_W, $clog2(NUM_REQ), width of the response ID (derived, not overridden).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  NUM_REQ  per-requester request valid.
req_ready  output  NUM_REQ  per-requester accept; at most one bit high.
req_x  input  NUM_REQ  operand x, bit i belongs to requester i.
req_y  input  NUM_REQ  operand y, bit i belongs to requester i.
req_op  input  3*NUM_REQ  opcode, bits [3i+2:3i] belong to requester i.
gu_x  output  1  x operand to the shared logic_gates unit.
gu_y  output  1  y operand to the shared logic_gates unit.
gu_out  input  7  outputs of the logic_gates unit, packed {g,f,e,d,c,b,a}; a at bit 0.
rsp_valid  output  1  response valid.
rsp_ready  input  1  response accept from the consumer.
rsp_id  output  ID_W  index of the requester that owns the response.
rsp_data  output  1  selected gate result.
rsp_err  output  1  set when the opcode was illegal.
busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Opcode map: 0=AND(a), 1=OR(b), 2=NAND(c), 3=NOR(d), 4=XOR(e), 5=XNOR(f), 6=NOT x(g), 7=illegal.
- Reset values: all outputs 0, FSM=IDLE, rr_ptr=0, operand/op/id registers 0.
- FSM states: IDLE, EVAL, RESP.
- IDLE:
  - grant = first i with req_valid[i]=1, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - req_ready is combinational: one-hot on grant when state==IDLE and any req_valid is high; otherwise all 0.
  - On handshake: capture x, y, op and id into registers; rr_ptr <= (id+1) mod NUM_REQ; next state EVAL.
  - With no request pending, stay in IDLE.
- gu_x/gu_y are driven directly from the captured registers, so the new operands are stable at the unit from the cycle after acceptance. They hold their last value while the FSM is idle.
- EVAL (one cycle):
  - rsp_data <= gu_out[op] for op 0..6; for op 7, rsp_data <= 0 and rsp_err <= 1, otherwise rsp_err <= 0.
  - rsp_id <= captured id; rsp_valid <= 1; next state RESP.
- RESP:
  - rsp_valid, rsp_id, rsp_data and rsp_err are held stable until rsp_ready=1.
  - On that edge rsp_valid <= 0 and the FSM returns to IDLE.
  - No new request is accepted in the same cycle as the response handshake.
- Latency: acceptance edge to rsp_valid = 2 cycles. Minimum issue interval is 3 cycles with rsp_ready held high.
- Fairness: a continuously asserting requester waits at most NUM_REQ-1 grants.
- Changes to req_* inputs while the FSM is not in IDLE are ignored. A requester's valid may drop before it is granted; this is legal.
- Reset mid-operation: the in-flight request is discarded and all state returns to reset values immediately (asynchronous). rsp_valid is never asserted for the dropped request.
- Internal state is never X after reset regardless of gu_out.

Decomposition:
- Package gate_op_pkg holds:
  - the opcode localparams OP_AND..OP_NOT and OP_ILLEGAL;
  - the gu_out bit-index constants;
  - the FSM state enum typedef (IDLE/EVAL/RESP).
- One sub-module, rr_picker: combinational round-robin search taking req_valid and rr_ptr, producing a one-hot grant, the grant index and any_valid. It is reused by later arbiters.
- The bench instantiates a real logic_gates unit on gu_x/gu_y/gu_out.

Test Plan:
- Single request: requester 2 issues x=1, y=0, op=4 (XOR), rsp_ready=1. Required: req_ready[2] in cycle 0, rsp_valid in cycle 2 with rsp_id=2, rsp_data=1, rsp_err=0; busy high for cycles 1-2.
- Full truth table: requester 0 sweeps all (x,y) pairs for ops 0..6. Every rsp_data must match the reference model (e.g. x=1, y=1, op=2 gives 0; x=0, y=0, op=6 gives 1).
- Round robin: all four requesters held valid continuously. Grant order must be 0,1,2,3,0,... across 8 responses, with rr_ptr wrapping from 3 to 0.
- Back-pressure: rsp_ready=0 for 5 cycles after rsp_valid. Response fields must stay stable, req_ready must stay all-0 and busy high; the response completes on the cycle rsp_ready goes to 1.
- Illegal opcode: op=7 from requester 1. Required: rsp_err=1, rsp_data=0, rsp_id=1; the next legal request clears rsp_err.
- Reset during EVAL: assert rst_n=0. All outputs must go to 0 asynchronously; after release, rsp_valid stays 0 and the next grant search starts at requester 0.
